// File: rtl/sc_neuron_arbiter.sv
// Round-robin arbiter that time-shares one stochastic-computing neuron datapath.
// A granted job clears the datapath for one cycle, streams BITS bit slots through it,
// collects the serial output bits into a shadow word and publishes them as result.
module sc_neuron_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned BITS = 64,
    localparam int unsigned IW  = $clog2(NREQ),
    localparam int unsigned BW  = $clog2(BITS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            abort,
    output logic [NREQ-1:0] gnt,
    output logic            dp_clear,
    output logic            dp_bit_en,
    output logic [BW-1:0]   bit_idx,
    input  logic            dp_out_bit,
    output logic [BITS-1:0] result,
    output logic [IW-1:0]   result_id,
    output logic [NREQ-1:0] done,
    output logic            busy
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gidx;
    logic [BITS-1:0] shadow;

    logic [IW-1:0]   sel;
    logic [IW-1:0]   cand;
    logic            any_req;
    logic [NREQ-1:0] sel_oh;
    logic [IW-1:0]   sel_inc;
    logic            last_bit;
    logic [BITS-1:0] shadow_nxt;

    // Pick the first requester at or after rr_ptr, scanning circularly.
    always_comb begin
        sel     = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((32'(rr_ptr) + 32'(k)) % NREQ);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                sel     = cand;
            end
        end
    end

    // One-hot form of the winner and the pointer value that makes it lowest priority next.
    always_comb begin
        sel_oh      = '0;
        sel_oh[sel] = 1'b1;
        sel_inc     = (sel == IW'(NREQ - 1)) ? '0 : sel + IW'(1);
    end

    // Shadow word including the bit arriving this cycle, so the final bit lands in result.
    always_comb begin
        shadow_nxt          = shadow;
        shadow_nxt[bit_idx] = dp_out_bit;
    end

    assign last_bit  = (bit_idx == BW'(BITS - 1));
    assign busy      = (state != StIdle);
    assign dp_clear  = (state == StLoad);
    assign dp_bit_en = (state == StRun);

    // Job sequencer: arbitration, bit streaming, result publication and abort handling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            rr_ptr    <= '0;
            gidx      <= '0;
            gnt       <= '0;
            bit_idx   <= '0;
            shadow    <= '0;
            result    <= '0;
            result_id <= '0;
            done      <= '0;
        end else begin
            done <= '0;
            case (state)
                StIdle: begin
                    bit_idx <= '0;
                    if (any_req) begin
                        state  <= StLoad;
                        gnt    <= sel_oh;
                        gidx   <= sel;
                        rr_ptr <= sel_inc;
                    end
                end
                StLoad: begin
                    bit_idx <= '0;
                    if (abort) begin
                        state <= StIdle;
                        gnt   <= '0;
                    end else begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    if (abort) begin
                        state   <= StIdle;
                        gnt     <= '0;
                        bit_idx <= '0;
                    end else begin
                        shadow <= shadow_nxt;
                        if (last_bit) begin
                            // bit_idx parks at BITS-1 until the job retires
                            state     <= StDone;
                            result    <= shadow_nxt;
                            result_id <= gidx;
                            done      <= gnt;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end
                end
                StDone: begin
                    state   <= StIdle;
                    gnt     <= '0;
                    bit_idx <= '0;
                end
                default: begin
                    state <= StIdle;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_neuron_arbiter.sv
// Self-checking bench for sc_neuron_arbiter: reset, round robin, table-driven jobs,
// abort in RUN/LOAD, reset mid-RUN and request drop.
module tb_sc_neuron_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic        abort;
    logic [3:0]  gnt;
    logic        dp_clear;
    logic        dp_bit_en;
    logic [5:0]  bit_idx;
    logic        dp_out_bit;
    logic [63:0] result;
    logic [1:0]  result_id;
    logic [3:0]  done;
    logic        busy;

    logic [63:0] pattern;
    int          cyc;
    int          checks;
    int          failures;

    sc_neuron_arbiter #(
        .NREQ(4),
        .BITS(64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .abort     (abort),
        .gnt       (gnt),
        .dp_clear  (dp_clear),
        .dp_bit_en (dp_bit_en),
        .bit_idx   (bit_idx),
        .dp_out_bit(dp_out_bit),
        .result    (result),
        .result_id (result_id),
        .done      (done),
        .busy      (busy)
    );

    // Stand-in datapath: its serial output is the pattern bit at the current index.
    assign dp_out_bit = dp_bit_en & pattern[bit_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  req;
        logic [63:0] pat;
        bit          drop;
        logic [3:0]  gnt;
        logic [1:0]  id;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done != 4'b0000) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // One complete job starting in an IDLE cycle, checked at LOAD, first RUN cycle and DONE.
    task automatic run_row(input vec_t v, input int r);
        int start;
        bit seen;
        req     = v.req;
        pattern = v.pat;
        start   = cyc;
        tick();
        check($sformatf("r%0d_gnt", r), 64'(gnt), 64'(v.gnt));
        check($sformatf("r%0d_clear", r), 64'(dp_clear), 64'(1));
        check($sformatf("r%0d_busy", r), 64'(busy), 64'(1));
        tick();
        check($sformatf("r%0d_bit_en", r), 64'(dp_bit_en), 64'(1));
        check($sformatf("r%0d_bit_idx0", r), 64'(bit_idx), 64'(0));
        check($sformatf("r%0d_clear_off", r), 64'(dp_clear), 64'(0));
        if (v.drop) req = 4'b0000;
        wait_done(seen);
        check($sformatf("r%0d_done_seen", r), 64'(seen), 64'(1));
        check($sformatf("r%0d_done_lat", r), 64'(cyc - start), 64'(66));
        check($sformatf("r%0d_done", r), 64'(done), 64'(v.gnt));
        check($sformatf("r%0d_result", r), result, v.pat);
        check($sformatf("r%0d_result_id", r), 64'(result_id), 64'(v.id));
        check($sformatf("r%0d_gnt_done", r), 64'(gnt), 64'(v.gnt));
        check($sformatf("r%0d_bit_en_done", r), 64'(dp_bit_en), 64'(0));
        req = 4'b0000;
        tick();
        check($sformatf("r%0d_idle_busy", r), 64'(busy), 64'(0));
        check($sformatf("r%0d_idle_gnt", r), 64'(gnt), 64'(0));
        check($sformatf("r%0d_idle_done", r), 64'(done), 64'(0));
        tick();
        check($sformatf("r%0d_stay_idle", r), 64'(busy), 64'(0));
    endtask

    initial begin
        int  start;
        int  prev;
        bit  seen;
        logic [63:0] rr_pat;
        logic [63:0] last_res;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        abort    = 1'b0;
        pattern  = '0;

        // rr_ptr starts at 0 after reset: 0100 -> 2 (ptr 3), 0001 -> 0 (ptr 1),
        // 1001 -> 3 (ptr 0), 1001 -> 0 (ptr 1), 0110 -> 1 (ptr 2), 0011 -> 0 (ptr 1)
        tbl[0] = '{req: 4'b0100, pat: 64'h5555_5555_5555_5555, drop: 1'b0, gnt: 4'b0100, id: 2'd2};
        tbl[1] = '{req: 4'b0001, pat: 64'hFFFF_FFFF_FFFF_FFFF, drop: 1'b0, gnt: 4'b0001, id: 2'd0};
        tbl[2] = '{req: 4'b1001, pat: 64'h8000_0000_0000_0001, drop: 1'b0, gnt: 4'b1000, id: 2'd3};
        tbl[3] = '{req: 4'b1001, pat: 64'h0123_4567_89AB_CDEF, drop: 1'b0, gnt: 4'b0001, id: 2'd0};
        tbl[4] = '{req: 4'b0110, pat: 64'h0000_0000_0000_0000, drop: 1'b1, gnt: 4'b0010, id: 2'd1};
        tbl[5] = '{req: 4'b0011, pat: 64'hA5A5_0F0F_F00F_3C3C, drop: 1'b1, gnt: 4'b0001, id: 2'd0};

        // Reset values
        tick();
        tick();
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_clear", 64'(dp_clear), 64'(0));
        check("rst_bit_en", 64'(dp_bit_en), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_bit_idx", 64'(bit_idx), 64'(0));
        check("rst_result", result, 64'(0));
        check("rst_result_id", 64'(result_id), 64'(0));
        rst = 1'b0;
        tick();

        // Round robin with all requests held: grants 0,1,2,3, done every 67 cycles
        rr_pat  = 64'hDEAD_BEEF_0123_4567;
        pattern = rr_pat;
        req     = 4'b1111;
        start   = cyc;
        prev    = cyc;
        for (int j = 0; j < 4; j++) begin
            wait_done(seen);
            check($sformatf("rr%0d_done_seen", j), 64'(seen), 64'(1));
            check($sformatf("rr%0d_spacing", j), 64'(cyc - prev), 64'((j == 0) ? 66 : 67));
            check($sformatf("rr%0d_done", j), 64'(done), 64'(4'b0001 << j));
            check($sformatf("rr%0d_result_id", j), 64'(result_id), 64'(j));
            check($sformatf("rr%0d_result", j), result, rr_pat);
            prev = cyc;
            if (j == 3) req = 4'b0000;
        end
        check("rr_total", 64'(cyc - start), 64'(66 + 3 * 67));
        tick();
        check("rr_idle_busy", 64'(busy), 64'(0));

        // Table-driven single jobs
        for (int r = 0; r < 6; r++) run_row(tbl[r], r);
        last_res = tbl[5].pat;

        // Abort at RUN bit_idx=10 (rr_ptr=1): grant 2, then abort
        req = 4'b0100;
        tick();
        check("ab_gnt", 64'(gnt), 64'(4'b0100));
        req = 4'b0000;
        tick();
        for (int i = 0; i < 10; i++) tick();
        check("ab_bit_idx", 64'(bit_idx), 64'(10));
        check("ab_bit_en", 64'(dp_bit_en), 64'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", 64'(busy), 64'(0));
        check("ab_gnt_clr", 64'(gnt), 64'(0));
        check("ab_bit_en_clr", 64'(dp_bit_en), 64'(0));
        check("ab_no_done", 64'(done), 64'(0));
        check("ab_result_hold", result, last_res);
        check("ab_result_id_hold", 64'(result_id), 64'(0));
        tick();
        check("ab_no_done_late", 64'(done), 64'(0));

        // Next grant goes to aborted index + 1, then abort that job in LOAD
        req = 4'b1111;
        tick();
        check("ab_next_gnt", 64'(gnt), 64'(4'b1000));
        check("ld_clear", 64'(dp_clear), 64'(1));
        abort = 1'b1;
        tick();
        check("ld_ab_busy", 64'(busy), 64'(0));
        check("ld_ab_gnt", 64'(gnt), 64'(0));
        check("ld_ab_no_done", 64'(done), 64'(0));

        // Abort held in IDLE is ignored; rr_ptr advanced to 0 by the aborted LOAD
        tick();
        check("idle_ab_gnt", 64'(gnt), 64'(4'b0001));
        check("idle_ab_busy", 64'(busy), 64'(1));
        abort = 1'b0;
        req   = 4'b0000;
        tick();
        for (int i = 0; i < 30; i++) tick();
        check("rs_bit_idx", 64'(bit_idx), 64'(30));

        // Reset mid-RUN clears everything asynchronously
        rst = 1'b1;
        #1;
        check("rs_gnt", 64'(gnt), 64'(0));
        check("rs_busy", 64'(busy), 64'(0));
        check("rs_bit_en", 64'(dp_bit_en), 64'(0));
        check("rs_bit_idx0", 64'(bit_idx), 64'(0));
        check("rs_result", result, 64'(0));
        check("rs_result_id", 64'(result_id), 64'(0));
        check("rs_done", 64'(done), 64'(0));
        tick();
        tick();
        check("rs_hold_done", 64'(done), 64'(0));
        check("rs_hold_busy", 64'(busy), 64'(0));
        rst = 1'b0;

        // First arbitration after release starts from rr_ptr=0
        req     = 4'b1010;
        pattern = 64'hCAFE_F00D_1234_5678;
        start   = cyc;
        tick();
        check("rs_gnt_after", 64'(gnt), 64'(4'b0010));
        wait_done(seen);
        check("rs_done_seen", 64'(seen), 64'(1));
        check("rs_done_lat", 64'(cyc - start), 64'(66));
        check("rs_done_bit", 64'(done), 64'(4'b0010));
        check("rs_job_result", result, 64'hCAFE_F00D_1234_5678);
        check("rs_job_id", 64'(result_id), 64'(1));
        req = 4'b0000;
        tick();
        check("rs_final_busy", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sc_neuron_arbiter.md
SC_NEURON_ARBITER -- requirements
Module: sc_neuron_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters sharing one SC neuron datapath (2..8).
REQ-002 The block SHALL have parameter BITS, default 64, meaning the stochastic bitstream length, with 64 supported.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have port req, input, NREQ, where bit i is a level request for one neuron evaluation by requester i.
REQ-006 The block SHALL have port abort, input, 1, a synchronous cancel of the current job.
REQ-007 The block SHALL have port gnt, output, NREQ, a one-hot grant held for the whole job and all-zero otherwise.
REQ-008 The block SHALL have port dp_clear, output, 1, a one-cycle pulse that resets the datapath FSM state and accumulators.
REQ-009 The block SHALL have port dp_bit_en, output, 1, asserted while the datapath consumes bit bit_idx.
REQ-010 The block SHALL have port bit_idx, output, clog2(BITS), the current stream bit index.
REQ-011 The block SHALL have port dp_out_bit, input, 1, the serial activated output bit for bit_idx, valid in the same cycle as dp_bit_en.
REQ-012 The block SHALL have port result, output, BITS, the assembled output stream of the last completed job.
REQ-013 The block SHALL have port result_id, output, clog2(NREQ), the requester index owning result.
REQ-014 The block SHALL have port done, output, NREQ, a one-cycle pulse on the bit of the requester whose job completed.
REQ-015 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
REQ-017 In IDLE with any req bit high, the arbiter SHALL select the first requester at or after rr_ptr (circular) and go to LOAD; with req all-zero it SHALL stay in IDLE.
REQ-018 Requests SHALL be sampled only in IDLE; a req change in LOAD, RUN or DONE SHALL have no effect on the current job.
REQ-019 LOAD SHALL last one cycle with gnt set and dp_clear=1, then go to RUN with bit_idx=0.
REQ-020 RUN SHALL last exactly BITS cycles with dp_bit_en=1 and bit_idx counting 0..BITS-1, with no wrap beyond BITS-1.
REQ-021 Each RUN cycle SHALL capture dp_out_bit into a shadow register at position bit_idx.
REQ-022 After the RUN cycle with bit_idx=BITS-1, the FSM SHALL go to DONE.
REQ-023 DONE SHALL last one cycle: result takes the shadow value, result_id the granted index, done[granted]=1 and gnt stays set; the next state SHALL be IDLE.
REQ-024 rr_ptr SHALL update to (granted+1) mod NREQ on entry to LOAD, so the winner has lowest priority in the next arbitration.
REQ-025 Latency from req sampled in IDLE (cycle t) SHALL be: gnt at t+1, RUN from t+2 to t+BITS+1, done at t+BITS+2, IDLE at t+BITS+3.
REQ-026 abort high in LOAD or RUN SHALL send the FSM to IDLE next cycle; gnt and dp_bit_en SHALL clear, no done SHALL pulse, result and result_id SHALL hold, and rr_ptr SHALL keep its advanced value.
REQ-027 abort in IDLE or DONE SHALL be ignored, and DONE SHALL complete normally.
REQ-028 Outside RUN, dp_bit_en SHALL be 0; outside LOAD, dp_clear SHALL be 0.
REQ-029 gnt SHALL never have more than one bit set.

Reset
REQ-030 While rst is high, the block SHALL hold state=IDLE, rr_ptr=0, bit_idx=0, gnt=0, done=0, dp_clear=0, dp_bit_en=0, busy=0, result=0 and result_id=0, asynchronously.
REQ-031 rst asserted mid-RUN SHALL discard the job with no done pulse; the first arbitration after release SHALL start from rr_ptr=0.

Verification
REQ-032 The bench SHALL cover single request: req=4'b0100 held, dp_out_bit=1 on even bit_idx -> gnt=4'b0100 at t+1, done=4'b0100 at t+66, result=64'h5555_5555_5555_5555, result_id=2.
REQ-033 The bench SHALL cover round robin: req=4'b1111 held for 4 jobs -> grant order 0,1,2,3 with done pulses spaced 67 cycles apart.
REQ-034 The bench SHALL cover fairness after a skip: rr_ptr=1, req=4'b1001 -> requester 3 is granted, then 0.
REQ-035 The bench SHALL cover abort: abort at RUN bit_idx=10 -> IDLE next cycle, no done, result unchanged, next grant goes to (aborted index+1).
REQ-036 The bench SHALL cover reset mid-RUN: rst pulse at bit_idx=30 -> all outputs 0 immediately; after release, req=4'b1010 -> gnt=4'b0010.
REQ-037 The bench SHALL cover request drop: req deasserted during RUN -> job still completes with a done pulse; req=0 afterwards -> block stays IDLE with busy=0.
